mem_stage_sram_ctrl: RTL and testbench

- MEM-stage data-memory controller, directly downstream of the execute stage.
- Consumes the execute result as a byte address and the Rm value as store data, and performs 32-bit loads/stores on an external 16-bit asynchronous SRAM as two half-word accesses.
- Drives ready low while an access is in progress; the pipeline uses ~ready as its freeze signal.

---
 rtl/mem_stage_sram_ctrl.sv | 125 ++++++++++++
 tb/tb_mem_stage_sram_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/mem_stage_sram_ctrl.sv
// rtl/mem_stage_sram_ctrl.sv - MEM-stage 32-bit load/store controller for a 16-bit asynchronous SRAM
module mem_stage_sram_ctrl #(
    parameter int ADDR_BASE   = 1024,
    parameter int WAIT_CYCLES = 2,
    parameter int SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    inout  wire  [15:0]        SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_CE_N
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LO   = 2'd1;
    localparam logic [1:0] HI   = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam int CW = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [SRAM_AW-2:0] lat_word;
    logic [31:0]        lat_data;
    logic               lat_wr;

    logic [31:0]        offset;
    logic [SRAM_AW-2:0] word;
    logic               last_cycle;
    logic               active;
    logic               dq_oe;
    logic [15:0]        dq_out;
    logic               unused_offset_bits;

    // Byte offset from the mapped base; wraps silently below ADDR_BASE.
    assign offset             = address - 32'(ADDR_BASE);
    assign word               = offset[SRAM_AW:2];
    assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

    assign last_cycle = (cnt == CNT_LAST);
    assign active     = (state == LO) || (state == HI);

    // Access sequencer: latch the request, run low then high half-word phases, then one DONE cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            read_data <= '0;
            lat_word  <= '0;
            lat_data  <= '0;
            lat_wr    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_en || rd_en) begin
                        lat_word <= word;
                        lat_data <= write_data;
                        lat_wr   <= wr_en;
                        cnt      <= '0;
                        state    <= LO;
                    end
                end
                LO: begin
                    if (last_cycle) begin
                        cnt   <= '0;
                        state <= HI;
                        if (!lat_wr) read_data[15:0] <= SRAM_DQ;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HI: begin
                    if (last_cycle) begin
                        cnt   <= '0;
                        state <= DONE;
                        if (!lat_wr) read_data[31:16] <= SRAM_DQ;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // SRAM pins and pipeline handshake decoded from state; WE_N lifts in the last phase cycle so
    // the address never moves under an active write strobe.
    always_comb begin
        ready     = 1'b0;
        SRAM_CE_N = 1'b1;
        SRAM_OE_N = 1'b1;
        SRAM_WE_N = 1'b1;
        SRAM_ADDR = '0;
        dq_oe     = 1'b0;
        dq_out    = 16'h0000;
        case (state)
            IDLE: ready = !(wr_en || rd_en);
            DONE: ready = 1'b1;
            default: ready = 1'b0;
        endcase
        if (active) begin
            SRAM_CE_N = 1'b0;
            SRAM_ADDR = {lat_word, (state == HI)};
            if (lat_wr) begin
                dq_oe     = 1'b1;
                dq_out    = (state == HI) ? lat_data[31:16] : lat_data[15:0];
                SRAM_WE_N = last_cycle;
            end else begin
                SRAM_OE_N = 1'b0;
            end
        end
    end

    assign SRAM_DQ = dq_oe ? dq_out : 16'hzzzz;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// tb/tb_mem_stage_sram_ctrl.sv - directed self-checking bench for mem_stage_sram_ctrl
module tb_mem_stage_sram_ctrl;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n;
    logic        sram_oe_n;
    logic        sram_ce_n;

    logic [15:0] mem [0:63];

    int checks = 0;
    int errors = 0;

    mem_stage_sram_ctrl #(
        .ADDR_BASE  (1024),
        .WAIT_CYCLES(2),
        .SRAM_AW    (18)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .address   (address),
        .write_data(write_data),
        .read_data (read_data),
        .ready     (ready),
        .SRAM_DQ   (sram_dq),
        .SRAM_ADDR (sram_addr),
        .SRAM_WE_N (sram_we_n),
        .SRAM_OE_N (sram_oe_n),
        .SRAM_CE_N (sram_ce_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous SRAM model: drives reads, stores at the clock edge closing a WE_N-low cycle.
    assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_addr[5:0]] : 16'hzzzz;

    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) mem[sram_addr[5:0]] <= sram_dq;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Issue one request at posedge+1 and follow it to the DONE cycle.
    task automatic access(input string tag, input logic w, input logic r,
                          input logic [31:0] a, input logic [31:0] d,
                          input int exp_we, input int exp_oe, input logic [31:0] exp_rd);
        int stall;
        int we_lo;
        int oe_lo;
        bit done;
        wr_en = w; rd_en = r; address = a; write_data = d;
        stall = 0; we_lo = 0; oe_lo = 0; done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (ready) begin
                done = 1;
            end else begin
                stall++;
                if (!sram_we_n) we_lo++;
                if (!sram_oe_n) oe_lo++;
                @(posedge clk);
            end
        end
        check({tag, "_done"}, {31'b0, done}, 32'd1);
        check({tag, "_stall"}, stall, 32'd5);
        check({tag, "_we_lows"}, we_lo, exp_we);
        check({tag, "_oe_lows"}, oe_lo, exp_oe);
        check({tag, "_done_ce_n"}, {31'b0, sram_ce_n}, 32'd1);
        check({tag, "_read_data"}, read_data, exp_rd);
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
        #2;
        check("rst_ready", {31'b0, ready}, 32'd1);
        check("rst_read_data", read_data, 32'h0);
        check("rst_ctl_n", {29'b0, sram_ce_n, sram_we_n, sram_oe_n}, 32'd7);
        check("rst_addr", {14'b0, sram_addr}, 32'h0);
        check("rst_dq_z", {31'b0, sram_dq === 16'hzzzz}, 32'd1);
        #20;
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_ready", {31'b0, ready}, 32'd1);
            check("idle_ce_n", {31'b0, sram_ce_n}, 32'd1);
            check("idle_dq_z", {31'b0, sram_dq === 16'hzzzz}, 32'd1);
        end
        @(posedge clk);
        #1;

        access("wr1024", 1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 2, 0, 32'h0);
        check("wr1024_mem0", {16'b0, mem[0]}, 32'h0000BEEF);
        check("wr1024_mem1", {16'b0, mem[1]}, 32'h0000DEAD);

        access("rd1024", 1'b0, 1'b1, 32'd1024, 32'h0, 0, 4, 32'hDEADBEEF);

        access("wrrd1032", 1'b1, 1'b1, 32'd1032, 32'h12345678, 2, 0, 32'hDEADBEEF);
        check("wrrd1032_mem4", {16'b0, mem[4]}, 32'h00005678);
        check("wrrd1032_mem5", {16'b0, mem[5]}, 32'h00001234);

        access("b2b_rd1024", 1'b0, 1'b1, 32'd1024, 32'h0, 0, 4, 32'hDEADBEEF);
        access("b2b_rd1032", 1'b0, 1'b1, 32'd1032, 32'h0, 0, 4, 32'h12345678);

        wr_en = 1'b1; address = 32'd1040; write_data = 32'hAABBCCDD;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_ce_n", {31'b0, sram_ce_n}, 32'd1);
        check("mid_rst_we_n", {31'b0, sram_we_n}, 32'd1);
        check("mid_rst_dq_z", {31'b0, sram_dq === 16'hzzzz}, 32'd1);
        check("mid_rst_read_data", read_data, 32'h0);
        check("mid_rst_mem8", {16'b0, mem[8]}, 32'h0000CCDD);
        wr_en = 1'b0;
        #1;
        check("mid_rst_ready", {31'b0, ready}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_ready", {31'b0, ready}, 32'd1);
        check("post_rst_ce_n", {31'b0, sram_ce_n}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
